gfx_cmd_scheduler: RTL and testbench

//   Shares the 8x8 rasterizer engine between two command requesters using round-robin arbitration.

---
 rtl/gfx_cmd_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_gfx_cmd_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_cmd_scheduler.sv
// gfx_cmd_scheduler
//   Shares one 8x8 rasterizer engine between two command requesters.
//   A combinational round-robin arbiter feeds a small command FIFO; a
//   four-state FSM pops one command at a time, pulses it to the engine,
//   waits for the engine's frame_start and then follows the PIXELS-long
//   pixel stream so nothing new is issued while a frame is in flight.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req{0,1}_valid/cmd/ready    requester handshakes (ready = granted this cycle)
//   gp_cmd, gp_valid            command to engine, one-cycle valid pulse
//   gp_frame_start              engine frame_start (only honoured in S_WAIT_START)
//   pixel_valid, pixel_index    pixel_data qualifier and {row,col} index
//   frame_done                  one-cycle pulse the cycle after the last pixel
//   fifo_count                  FIFO occupancy 0..FIFO_DEPTH
//   timeout_err                 sticky flag, set when the engine never starts a frame
module gfx_cmd_scheduler #(
  parameter int CMD_W      = 20,
  parameter int FIFO_DEPTH = 4,
  parameter int PIXELS     = 64,
  parameter int TIMEOUT    = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req0_valid,
  input  logic [CMD_W-1:0]                  req0_cmd,
  output logic                              req0_ready,
  input  logic                              req1_valid,
  input  logic [CMD_W-1:0]                  req1_cmd,
  output logic                              req1_ready,
  output logic [CMD_W-1:0]                  gp_cmd,
  output logic                              gp_valid,
  input  logic                              gp_frame_start,
  output logic                              pixel_valid,
  output logic [$clog2(PIXELS)-1:0]         pixel_index,
  output logic                              frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              timeout_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = $clog2(PIXELS);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PIX_LAST = PW'(PIXELS-1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_STREAM
  } state_t;

  state_t state_q, state_d;

  // ---------------- arbiter ----------------
  logic            rr_q;     // 0: req0 preferred on a tie, 1: req1
  logic [1:0]      gnt;
  logic            push, pop;
  logic [CMD_W-1:0] push_cmd;

  // Occupancy is the registered count, so a full FIFO refuses grants even
  // in the cycle it is being popped.
  always_comb begin
    gnt = 2'b00;
    if (fifo_count < DEPTH_C) begin
      if (req0_valid && req1_valid) gnt[rr_q] = 1'b1;
      else if (req0_valid)          gnt[0]    = 1'b1;
      else if (req1_valid)          gnt[1]    = 1'b1;
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign push       = |gnt;
  assign push_cmd   = gnt[1] ? req1_cmd : req0_cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr_q <= 1'b0;
    else if (gnt[0]) rr_q <= 1'b1;
    else if (gnt[1]) rr_q <= 1'b0;
  end

  // ---------------- command FIFO ----------------
  logic [CMD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt_q;

  assign fifo_count = cnt_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_cmd;
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  // ---------------- issue FSM ----------------
  logic [CMD_W-1:0] gp_cmd_q;
  logic [TW-1:0]    timer_q;
  logic [PW-1:0]    pix_q;
  logic             done_q, err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE:      state_d = S_WAIT_START;
      S_WAIT_START: begin
        if (gp_frame_start)          state_d = S_STREAM;
        else if (timer_q == TMR_LAST) state_d = S_IDLE;
      end
      S_STREAM: begin
        if (pix_q == PIX_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The frame_start cycle itself carries pixel 0, so the stream counter
  // enters S_STREAM already pointing at pixel 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gp_cmd_q <= '0;
      timer_q  <= '0;
      pix_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pop) gp_cmd_q <= mem[rd_ptr];
      case (state_q)
        S_ISSUE: timer_q <= '0;
        S_WAIT_START: begin
          if (gp_frame_start)           pix_q   <= PW'(1);
          else if (timer_q == TMR_LAST) err_q   <= 1'b1;
          else                          timer_q <= timer_q + 1'b1;
        end
        S_STREAM: begin
          if (pix_q == PIX_LAST) begin
            pix_q  <= '0;
            done_q <= 1'b1;
          end else begin
            pix_q <= pix_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign gp_cmd      = gp_cmd_q;
  assign gp_valid    = (state_q == S_ISSUE);
  assign pixel_valid = (state_q == S_STREAM) || ((state_q == S_WAIT_START) && gp_frame_start);
  assign pixel_index = pix_q;
  assign frame_done  = done_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_gfx_cmd_scheduler.sv
// tb_gfx_cmd_scheduler
//   Random two-requester traffic against gfx_cmd_scheduler with a small
//   engine model that raises frame_start two cycles after each accepted
//   command (or never, when muted). A transaction-level reference model
//   predicts grants, FIFO occupancy and the absolute cycle of every
//   command issue, pixel window, frame_done and timeout; a negedge monitor
//   compares the DUT against those predictions.
module tb_gfx_cmd_scheduler;
  localparam int CMD_W   = 20;
  localparam int DEPTH   = 4;
  localparam int PIXELS  = 64;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [CMD_W-1:0] req0_cmd = '0, req1_cmd = '0;
  logic req0_ready, req1_ready, gp_valid, gp_frame_start;
  logic pixel_valid, frame_done, timeout_err;
  logic [CMD_W-1:0] gp_cmd;
  logic [5:0] pixel_index;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  gfx_cmd_scheduler #(.CMD_W(CMD_W), .FIFO_DEPTH(DEPTH), .PIXELS(PIXELS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_ready(req1_ready),
    .gp_cmd(gp_cmd), .gp_valid(gp_valid), .gp_frame_start(gp_frame_start),
    .pixel_valid(pixel_valid), .pixel_index(pixel_index), .frame_done(frame_done),
    .fifo_count(fifo_count), .timeout_err(timeout_err)
  );

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- engine model ----------------
  // The monitor records, per predicted issue, whether the engine answers.
  bit plan [256];
  int plan_wr = 0, plan_rd = 0;
  logic fs_d1 = 1'b0, fs_d2 = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_d1 <= 1'b0; fs_d2 <= 1'b0; plan_rd <= 0;
    end else begin
      fs_d2 <= fs_d1;
      fs_d1 <= 1'b0;
      if (gp_valid) begin
        fs_d1   <= plan[plan_rd % 256];
        plan_rd <= plan_rd + 1;
      end
    end
  end
  assign gp_frame_start = fs_d2;

  // ---------------- reference model + monitor ----------------
  typedef struct { int cyc; logic [CMD_W-1:0] cmd; } gp_ev_t;
  logic [CMD_W-1:0] mq [$];   // expected FIFO contents in grant order
  gp_ev_t gpq [$];            // expected command issues
  int frq [$];                // expected cycle of pixel 0 for each frame
  int rr = 0;                 // 0: req0 wins a tie
  int next_free = 0;          // first cycle the scheduler can pop again
  int err_at = -1;            // cycle timeout_err becomes visible
  int issued = 0;
  bit mute = 1'b0;
  bit got0 = 1'b0, got1 = 1'b0;

  always @(negedge clk) begin : mon
    bit ok, e0, e1, ev, pv, fd;
    int n;
    logic [CMD_W-1:0] c;
    n = cyc;
    got0 = rst_n && req0_valid && req0_ready;
    got1 = rst_n && req1_valid && req1_ready;
    if (!rst_n) begin
      mq.delete(); gpq.delete(); frq.delete();
      rr = 0; next_free = 0; err_at = -1; plan_wr = 0;
    end else begin
      ok = (mq.size() < DEPTH);
      e0 = ok && req0_valid && (!req1_valid || rr == 0);
      e1 = ok && req1_valid && (!req0_valid || rr == 1);
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
      chk("fifo_count", {29'd0, fifo_count}, mq.size());
      chk("timeout_err", {31'd0, timeout_err}, {31'd0, (err_at >= 0) && (n >= err_at)});
      ev = (gpq.size() > 0) && (gpq[0].cyc == n);
      chk("gp_valid", {31'd0, gp_valid}, {31'd0, ev});
      if (ev) begin
        chk("gp_cmd", {12'd0, gp_cmd}, {12'd0, gpq[0].cmd});
        void'(gpq.pop_front());
      end
      pv = (frq.size() > 0) && (n >= frq[0]) && (n < frq[0] + PIXELS);
      chk("pixel_valid", {31'd0, pixel_valid}, {31'd0, pv});
      if (pv) chk("pixel_index", {26'd0, pixel_index}, n - frq[0]);
      fd = (frq.size() > 0) && (n == frq[0] + PIXELS);
      chk("frame_done", {31'd0, frame_done}, {31'd0, fd});
      if (fd) void'(frq.pop_front());
      // Pop (scheduler idle, FIFO non-empty) is decided before this cycle's push.
      if (n >= next_free && mq.size() > 0) begin
        c = mq.pop_front();
        gpq.push_back('{cyc: n + 1, cmd: c});
        plan[plan_wr % 256] = !mute;
        plan_wr++;
        issued++;
        if (mute) begin
          next_free = n + 2 + TIMEOUT;
          if (err_at < 0) err_at = n + 2 + TIMEOUT;
        end else begin
          frq.push_back(n + 3);
          next_free = n + 3 + PIXELS;
        end
      end
      if (e0)      begin mq.push_back(req0_cmd); rr = 1; end
      else if (e1) begin mq.push_back(req1_cmd); rr = 0; end
    end
  end

  // ---------------- stimulus ----------------
  logic [CMD_W-1:0] pend0 [$], pend1 [$];
  int p0 = 100, p1 = 100;
  int sent = 0;

  task automatic step();
    @(posedge clk); #1;
    if (got0) req0_valid = 1'b0;
    if (got1) req1_valid = 1'b0;
    if (!req0_valid && pend0.size() > 0 && $urandom_range(0, 99) < p0) begin
      req0_cmd = pend0.pop_front(); req0_valid = 1'b1;
    end
    if (!req1_valid && pend1.size() > 0 && $urandom_range(0, 99) < p1) begin
      req1_cmd = pend1.pop_front(); req1_valid = 1'b1;
    end
  endtask

  task automatic add(int who, logic [CMD_W-1:0] c);
    if (who == 0) pend0.push_back(c); else pend1.push_back(c);
    sent++;
  endtask

  task automatic wait_idle(string nm);
    int k;
    k = 0;
    while (!(pend0.size() == 0 && pend1.size() == 0 && !req0_valid && !req1_valid &&
             mq.size() == 0 && gpq.size() == 0 && frq.size() == 0 && cyc >= next_free)) begin
      step();
      k++;
      if (k > 3000) begin
        checks++; failures++;
        $display("FAIL %s wait bound expired after %0d cycles", nm, k);
        return;
      end
    end
    repeat (2) step();
  endtask

  task automatic check_zero(string nm);
    chk({nm, "_req0_ready"},  {31'd0, req0_ready}, 0);
    chk({nm, "_req1_ready"},  {31'd0, req1_ready}, 0);
    chk({nm, "_gp_cmd"},      {12'd0, gp_cmd}, 0);
    chk({nm, "_gp_valid"},    {31'd0, gp_valid}, 0);
    chk({nm, "_pixel_valid"}, {31'd0, pixel_valid}, 0);
    chk({nm, "_pixel_index"}, {26'd0, pixel_index}, 0);
    chk({nm, "_frame_done"},  {31'd0, frame_done}, 0);
    chk({nm, "_fifo_count"},  {29'd0, fifo_count}, 0);
    chk({nm, "_timeout_err"}, {31'd0, timeout_err}, 0);
  endtask

  initial begin
    int k, base;
    logic [CMD_W-1:0] c;
    #2 check_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // single command from req0
    add(0, 20'h4_5000);
    wait_idle("single");

    // both requesters saturated: alternation, full FIFO while streaming
    for (int i = 0; i < 4; i++) begin
      c = CMD_W'($urandom()); add(0, c);
      c = CMD_W'($urandom()); add(1, c);
    end
    wait_idle("saturate");

    // engine silent for the first of two commands
    mute = 1'b1;
    base = issued;
    add(1, CMD_W'($urandom()));
    add(1, CMD_W'($urandom()));
    k = 0;
    while (issued == base && k < 200) begin step(); k++; end
    mute = 1'b0;
    wait_idle("timeout");
    chk("timeout_err_sticky", {31'd0, timeout_err}, 1);

    // random traffic
    p0 = $urandom_range(20, 90);
    p1 = $urandom_range(20, 90);
    for (int i = 0; i < 10; i++) begin
      add(0, CMD_W'($urandom()));
      add(1, CMD_W'($urandom()));
    end
    wait_idle("random");
    p0 = 100; p1 = 100;

    // reset in the middle of a frame
    add(0, CMD_W'($urandom()));
    k = 0;
    while (!(pixel_valid && pixel_index == 6'd30) && k < 300) begin step(); k++; end
    if (k >= 300) begin
      checks++; failures++;
      $display("FAIL midframe wait bound expired");
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1 check_zero("midreset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // normal operation after release
    add(1, 20'h1_2345);
    wait_idle("after_reset");
    chk("issued_vs_sent", issued, sent);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
